// File: rtl/lab1a_operand_loader.sv
// rtl/lab1a_operand_loader.sv - captures two operands from sw and drives x/y/s of a downstream 2:1 mux
// Optional feature macro: LAB1A_AUTO_TOGGLE_EN (counter-driven s toggling in RUN instead of ld-driven).
module lab1a_operand_loader #(
    parameter int unsigned PERIOD = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    input  logic       ld,
    input  logic       clr,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       s,
    output logic       valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GET_Y = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ld_q;
    logic        w_ld_rise;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic        r_s;
    logic        r_valid;
    logic        w_s_nxt;
    logic        w_valid_nxt;
    logic        w_toggle;

    if (PERIOD < 1 || PERIOD > 65535) begin : g_bad_period
        $error("PERIOD must be in 1..65535");
    end

    assign w_ld_rise = ld & ~r_ld_q;

`ifdef LAB1A_AUTO_TOGGLE_EN
    localparam logic [15:0] LP_LAST = 16'(PERIOD - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_wrap;

    assign w_wrap   = (r_cnt == LP_LAST);
    assign w_toggle = w_wrap;

    // Counter only advances in RUN; any other state (or clr) leaves it at 0 for the next RUN entry.
    always_comb begin
        w_cnt_nxt = '0;
        if (!clr && r_state == ST_RUN && !w_wrap) begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_toggle = w_ld_rise;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_s_nxt     = r_s;
        w_valid_nxt = r_valid;
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_s_nxt     = 1'b0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_s_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                    if (w_ld_rise) begin
                        w_x_nxt     = sw;
                        w_state_nxt = ST_GET_Y;
                    end
                end
                ST_GET_Y: begin
                    w_s_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                    if (w_ld_rise) begin
                        w_y_nxt     = sw;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_valid_nxt = 1'b1;
                    if (w_toggle) begin
                        w_s_nxt = ~r_s;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_s_nxt     = 1'b0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // ld_q resets high so a level held through reset is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ld_q  <= 1'b1;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_s     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ld_q  <= ld;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_s     <= w_s_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign s     = r_s;
    assign valid = r_valid;

endmodule

// File: tb/tb_lab1a_operand_loader.sv
// tb/tb_lab1a_operand_loader.sv - self-checking bench for lab1a_operand_loader
module tb_lab1a_operand_loader;

    localparam int TB_PERIOD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       ld;
    logic       clr;
    logic [7:0] x;
    logic [7:0] y;
    logic       s;
    logic       valid;

    int checks = 0;
    int failures = 0;

    lab1a_operand_loader #(.PERIOD(TB_PERIOD)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .ld    (ld),
        .clr   (clr),
        .x     (x),
        .y     (y),
        .s     (s),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       l;
        logic       c;
        logic [7:0] w;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       es;
        logic       ev;
    } vec_t;

    vec_t vq[$];

    // Reference model state: operands, load phase, RUN cycle count, manual toggle count
    int         m_phase;
    logic [7:0] mx;
    logic [7:0] my;
    int         m_run;
    int         m_tog;
    logic       m_ldq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic c, input logic [7:0] w,
                       input logic [7:0] ex, input logic [7:0] ey, input logic es, input logic ev);
        vec_t v;
        v.rst = r; v.l = l; v.c = c; v.w = w;
        v.ex = ex; v.ey = ey; v.es = es; v.ev = ev;
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic r, input logic l, input logic c, input logic [7:0] w);
        logic rise;
        rise = l && !m_ldq;
        if (r) begin
            m_phase = 0; mx = 8'h00; my = 8'h00; m_run = 0; m_tog = 0; m_ldq = 1'b1;
        end else begin
            m_ldq = l;
            if (c) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (rise) begin mx = w; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (rise) begin my = w; m_phase = 2; m_run = 0; m_tog = 0; end
            end else begin
                m_run++;
                if (rise) m_tog++;
            end
        end
    endtask

    function automatic logic model_s();
        if (m_phase != 2) return 1'b0;
`ifdef LAB1A_AUTO_TOGGLE_EN
        return logic'((m_run / TB_PERIOD) % 2);
`else
        return logic'(m_tog % 2);
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1; ld = 1'b0; clr = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; ld = 1'b1; clr = 1'b0; sw = 8'h00;

        // Scenario 1: reset with ld held, no capture after release
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'hAA, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 8'hAA, 8'h00, 8'h00, 0, 0);
        // Scenario 2: two loads
        add(0, 1, 0, 8'hA5, 8'hA5, 8'h00, 0, 0);
        add(0, 0, 0, 8'h3C, 8'hA5, 8'h00, 0, 0);
        add(0, 1, 0, 8'h3C, 8'hA5, 8'h3C, 0, 1);
        add(0, 0, 0, 8'h55, 8'hA5, 8'h3C, 0, 1);
        // Scenario 5: clr with ld rise in RUN, operands retained
        add(0, 1, 1, 8'h77, 8'hA5, 8'h3C, 0, 0);
        add(0, 0, 0, 8'h77, 8'hA5, 8'h3C, 0, 0);
        add(0, 1, 0, 8'hFF, 8'hFF, 8'h3C, 0, 0);
        add(0, 0, 1, 8'hFF, 8'hFF, 8'h3C, 0, 0);
        // Scenario 6: reset in GET_Y after x = 11, then normal sequence
        add(0, 1, 0, 8'h11, 8'h11, 8'h3C, 0, 0);
        add(1, 1, 0, 8'h11, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 8'h22, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 8'h22, 8'h22, 8'h00, 0, 0);
        add(0, 0, 0, 8'h33, 8'h22, 8'h00, 0, 0);
        add(0, 1, 0, 8'h33, 8'h22, 8'h33, 0, 1);
        add(0, 0, 0, 8'h44, 8'h22, 8'h33, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; ld = vq[i].l; clr = vq[i].c; sw = vq[i].w;
            step();
            chk($sformatf("vec%0d_x", i), 32'(x), 32'(vq[i].ex));
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vq[i].ey));
            chk($sformatf("vec%0d_s", i), 32'(s), 32'(vq[i].es));
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vq[i].ev));
        end

        do_reset();
        sw = 8'hA5; ld = 1'b1; step(); ld = 1'b0; step();
        sw = 8'h3C; ld = 1'b1; step();
        chk("run_entry_valid", 32'(valid), 32'd1);
        chk("run_entry_s", 32'(s), 32'd0);
        ld = 1'b0;
`ifdef LAB1A_AUTO_TOGGLE_EN
        // Scenario 3: s follows 0,0,0,0,1,1,1,1,0 ; ld in RUN ignored
        begin
            logic [8:0] pat;
            pat = 9'b0_1111_0000;
            for (int k = 1; k < 9; k++) begin
                step();
                chk($sformatf("auto_s_k%0d", k), 32'(s), 32'(pat[k]));
            end
            ld = 1'b1; step(); chk("auto_ld_k9", 32'(s), 32'd0);
            step(); chk("auto_ld_k10", 32'(s), 32'd0);
            ld = 1'b0; step(); chk("auto_ld_k11", 32'(s), 32'd0);
            step(); chk("auto_ld_k12", 32'(s), 32'd1);
        end
`else
        // Scenario 4: three long ld pulses each toggle s once
        for (int p = 0; p < 3; p++) begin
            step();
            ld = 1'b1;
            for (int c = 0; c < 5; c++) begin
                step();
                chk($sformatf("man_p%0d_c%0d_s", p, c), 32'(s), 32'((p + 1) % 2));
            end
            ld = 1'b0;
        end
        step();
        chk("man_final_s", 32'(s), 32'd1);
`endif
        chk("hold_x", 32'(x), 32'hA5);
        chk("hold_y", 32'(y), 32'h3C);
        chk("hold_valid", 32'(valid), 32'd1);

        // Randomized stimulus against the reference model
        reset = 1'b1; ld = $urandom_range(0, 1); clr = 1'b0; sw = 8'($urandom);
        step();
        model_edge(reset, ld, clr, sw);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            clr   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0) ld = ~ld;
            sw = 8'($urandom);
            step();
            model_edge(reset, ld, clr, sw);
            chk($sformatf("rnd%0d_x", n), 32'(x), 32'(mx));
            chk($sformatf("rnd%0d_y", n), 32'(y), 32'(my));
            chk($sformatf("rnd%0d_s", n), 32'(s), 32'(model_s()));
            chk($sformatf("rnd%0d_valid", n), 32'(valid), 32'(m_phase == 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab1a_operand_loader.md
LAB1A_OPERAND_LOADER -- requirements
Module: lab1a_operand_loader

Interface
REQ-001 SHALL have parameter PERIOD, default 50: RUN-state cycles between automatic s toggles; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port sw, input, 8 bits: operand value to capture.
REQ-005 SHALL have port ld, input, 1 bit: load/step request, level signal; only its rising edge acts.
REQ-006 SHALL have port clr, input, 1 bit: synchronous return to IDLE.
REQ-007 SHALL have port x, output, 8 bits: captured operand A, drives the downstream 2:1 mux x input.
REQ-008 SHALL have port y, output, 8 bits: captured operand B, drives the downstream mux y input.
REQ-009 SHALL have port s, output, 1 bit: select, drives the downstream mux s input (0 = x, 1 = y).
REQ-010 SHALL have port valid, output, 1 bit: high only while both operands are loaded and s is live.

Function
REQ-011 SHALL register ld into ld_q each cycle; ld_rise = ld & ~ld_q; ld held high produces exactly one ld_rise.
REQ-012 SHALL implement the FSM states IDLE, GET_Y and RUN; all outputs registered.
REQ-013 IDLE: on ld_rise, SHALL load x <= sw on that same edge and go to GET_Y; valid = 0, s = 0.
REQ-014 GET_Y: on ld_rise, SHALL load y <= sw on that edge and go to RUN; valid becomes 1 on that same edge.
REQ-015 RUN: valid = 1; s SHALL toggle according to REQ-026/REQ-027; x and y SHALL hold.
REQ-016 clr in any state SHALL go to IDLE on the next edge with s = 0 and valid = 0; x and y SHALL retain their values.
REQ-017 clr coincident with ld_rise: clr SHALL win; no capture and no toggle.
REQ-018 The toggle counter SHALL be 16 bits, SHALL be 0 on entry to RUN, and SHALL count 0..PERIOD-1 then wrap to 0.
REQ-019 PERIOD = 1: s SHALL toggle every RUN cycle.
REQ-020 x, y and s SHALL be stable for a full cycle; glitch-free, because the downstream mux is purely combinational.

Reset
REQ-021 reset SHALL take precedence over clr and ld.
REQ-022 reset SHALL force: state IDLE; x = 8'h00; y = 8'h00; s = 0; valid = 0; counter = 0.
REQ-023 reset SHALL force ld_q = 1, so ld held high through reset does not cause a capture.
REQ-024 Reset mid-operation (GET_Y or RUN) SHALL abandon the sequence and discard captured operands.

Configuration
REQ-025 SHALL use the macro LAB1A_AUTO_TOGGLE_EN.
REQ-026 With LAB1A_AUTO_TOGGLE_EN defined: in RUN, s SHALL toggle on the cycle the counter wraps (PERIOD-1 -> 0), and ld_rise in RUN SHALL be ignored.
REQ-027 Without LAB1A_AUTO_TOGGLE_EN: the counter SHALL be absent, and in RUN each ld_rise SHALL toggle s exactly once.

Verification
REQ-028 Scenario 1: reset 2 cycles with ld = 1 held, release -> x = 00, y = 00, s = 0, valid = 0, no capture.
REQ-029 Scenario 2: sw = 8'hA5, pulse ld; sw = 8'h3C, pulse ld -> x = A5, y = 3C, valid = 1 on the edge of the second ld_rise, s = 0.
REQ-030 Scenario 3 (macro defined, PERIOD = 4): after Scenario 2 -> s pattern 0,0,0,0,1,1,1,1,0,... ; an ld pulse during RUN causes no change.
REQ-031 Scenario 4 (macro undefined): in RUN, 3 ld pulses, each held 5 cycles -> s toggles 3 times, ending at 1; x and y unchanged.
REQ-032 Scenario 5: in RUN, assert clr together with an ld rise -> next edge: IDLE, valid = 0, s = 0, x = A5, y = 3C retained; the following ld with sw = 8'hFF gives x = FF.
REQ-033 Scenario 6: assert reset in GET_Y after x = 8'h11 -> x = 00 and state IDLE; the next two loads sequence normally.
